// File: rtl/lfsr_checker_16x4_if.sv
// rtl/lfsr_checker_16x4_if.sv - receive stream and status bundle for the 4-lane LFSR checker
interface lfsr_checker_16x4_if #(
    parameter int ERR_W = 32
);
    logic             rx_valid;
    logic [63:0]      rx_data;
    logic             clear_cnt;
    logic             locked;
    logic [3:0]       err_lane;
    logic [ERR_W-1:0] word_cnt;
    logic [ERR_W-1:0] bit_err_cnt;
    logic             err_sticky;

    modport master (
        output rx_valid, rx_data, clear_cnt,
        input  locked, err_lane, word_cnt, bit_err_cnt, err_sticky
    );

    modport slave (
        input  rx_valid, rx_data, clear_cnt,
        output locked, err_lane, word_cnt, bit_err_cnt, err_sticky
    );
endinterface

// File: rtl/lfsr_checker_16x4.sv
// rtl/lfsr_checker_16x4.sv - self-synchronising checker for the 4-lane 16-bit XNOR LFSR stream
module lfsr_checker_16x4 #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 4,
    parameter int ERR_W      = 32
) (
    input logic                clk,
    input logic                reset,
    lfsr_checker_16x4_if.slave bus
);
    localparam int MCW = $clog2(LOCK_COUNT + 1);
    localparam int LCW = $clog2(LOSS_COUNT + 1);
    localparam int SW  = ERR_W + 8;
    localparam logic [MCW-1:0] LOCK_LAST = MCW'(LOCK_COUNT - 1);
    localparam logic [LCW-1:0] LOSS_LAST = LCW'(LOSS_COUNT - 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t           r_state;
    logic [63:0]      r_pred;
    logic             r_pred_ok;
    logic [MCW-1:0]   r_match_cnt;
    logic [LCW-1:0]   r_miss_cnt;
    logic             r_locked;
    logic [3:0]       r_err_lane;
    logic [ERR_W-1:0] r_word_cnt;
    logic [ERR_W-1:0] r_bit_err_cnt;
    logic             r_err_sticky;

    logic [63:0]      w_nxt_rx;
    logic [63:0]      w_nxt_pred;
    logic [63:0]      w_diff;
    logic [3:0]       w_lane_err;
    logic [3:0]       w_lane_ffff;
    logic [6:0]       w_pop;
    logic             w_any_err;
    logic             w_match;
    logic [ERR_W-1:0] w_word_base;
    logic [ERR_W-1:0] w_word_next;
    logic [ERR_W-1:0] w_bit_base;
    logic [SW-1:0]    w_bit_sum;
    logic [ERR_W-1:0] w_bit_next;
    logic             w_sticky_base;

    function automatic logic [15:0] f_nxt(input logic [15:0] s);
        return {s[14:0], ~(s[3] ^ s[12] ^ s[14] ^ s[15])};
    endfunction

    always_comb begin
        w_nxt_rx    = '0;
        w_nxt_pred  = '0;
        w_lane_err  = '0;
        w_lane_ffff = '0;
        w_pop       = '0;
        w_diff      = bus.rx_data ^ r_pred;
        for (int i = 0; i < 4; i++) begin
            w_nxt_rx[16*i +: 16]   = f_nxt(bus.rx_data[16*i +: 16]);
            w_nxt_pred[16*i +: 16] = f_nxt(r_pred[16*i +: 16]);
            w_lane_err[i]          = |w_diff[16*i +: 16];
            w_lane_ffff[i]         = &bus.rx_data[16*i +: 16];
        end
        for (int b = 0; b < 64; b++) begin
            w_pop = w_pop + 7'(w_diff[b]);
        end
        w_any_err = |w_lane_err;
        w_match   = r_pred_ok && !w_any_err && !(|w_lane_ffff);
    end

    // clear_cnt rebases the counters to zero so the same-cycle word still counts
    always_comb begin
        w_word_base   = bus.clear_cnt ? '0 : r_word_cnt;
        w_bit_base    = bus.clear_cnt ? '0 : r_bit_err_cnt;
        w_sticky_base = bus.clear_cnt ? 1'b0 : r_err_sticky;
        w_word_next   = (&w_word_base) ? w_word_base : w_word_base + 1'b1;
        w_bit_sum     = SW'(w_bit_base) + SW'(w_pop);
        w_bit_next    = (|w_bit_sum[SW-1:ERR_W]) ? '1 : w_bit_sum[ERR_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= SEARCH;
            r_pred        <= '0;
            r_pred_ok     <= 1'b0;
            r_match_cnt   <= '0;
            r_miss_cnt    <= '0;
            r_locked      <= 1'b0;
            r_err_lane    <= '0;
            r_word_cnt    <= '0;
            r_bit_err_cnt <= '0;
            r_err_sticky  <= 1'b0;
        end else begin
            if (bus.clear_cnt) begin
                r_word_cnt    <= '0;
                r_bit_err_cnt <= '0;
                r_err_sticky  <= 1'b0;
            end
            if (bus.rx_valid) begin
                case (r_state)
                    SEARCH: begin
                        r_pred    <= w_nxt_rx;
                        r_pred_ok <= 1'b1;
                        if (!w_match) begin
                            r_match_cnt <= '0;
                        end else if (r_match_cnt == LOCK_LAST) begin
                            r_state     <= LOCKED;
                            r_locked    <= 1'b1;
                            r_match_cnt <= '0;
                            r_miss_cnt  <= '0;
                        end else begin
                            r_match_cnt <= r_match_cnt + 1'b1;
                        end
                    end
                    LOCKED: begin
                        // free-run so a corrupted word never becomes the new prediction
                        r_pred        <= w_nxt_pred;
                        r_err_lane    <= w_lane_err;
                        r_word_cnt    <= w_word_next;
                        r_bit_err_cnt <= w_bit_next;
                        r_err_sticky  <= w_sticky_base | w_any_err;
                        if (!w_any_err) begin
                            r_miss_cnt <= '0;
                        end else if (r_miss_cnt == LOSS_LAST) begin
                            r_state     <= SEARCH;
                            r_locked    <= 1'b0;
                            r_pred      <= w_nxt_rx;
                            r_pred_ok   <= 1'b1;
                            r_match_cnt <= '0;
                            r_miss_cnt  <= '0;
                            r_err_lane  <= '0;
                        end else begin
                            r_miss_cnt <= r_miss_cnt + 1'b1;
                        end
                    end
                    default: r_state <= SEARCH;
                endcase
            end
        end
    end

    assign bus.locked      = r_locked;
    assign bus.err_lane    = r_err_lane;
    assign bus.word_cnt    = r_word_cnt;
    assign bus.bit_err_cnt = r_bit_err_cnt;
    assign bus.err_sticky  = r_err_sticky;
endmodule

// File: tb/tb_lfsr_checker_16x4.sv
// tb/tb_lfsr_checker_16x4.sv - directed table-driven bench for lfsr_checker_16x4
module tb_lfsr_checker_16x4;
    localparam int ERR_W = 8;

    typedef struct {
        logic        v;
        logic        c;
        logic [63:0] mask;
        logic        e_locked;
        logic [3:0]  e_lane;
        logic [7:0]  e_word;
        logic [7:0]  e_bit;
        logic        e_sticky;
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [63:0] gen;
    vec_t tbl_a[5];
    vec_t tbl_b[15];

    lfsr_checker_16x4_if #(.ERR_W(ERR_W)) bus ();

    lfsr_checker_16x4 #(
        .LOCK_COUNT(4),
        .LOSS_COUNT(4),
        .ERR_W     (ERR_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] nxt64(input logic [63:0] s);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) begin
            r[16*i +: 16] = {s[16*i +: 15],
                             ~(s[16*i+3] ^ s[16*i+12] ^ s[16*i+14] ^ s[16*i+15])};
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [63:0] d, input logic c);
        @(negedge clk);
        bus.rx_valid  = v;
        bus.rx_data   = d;
        bus.clear_cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t t, input string tag);
        step(t.v, gen ^ t.mask, t.c);
        if (t.v) gen = nxt64(gen);
        chk({tag, ".locked"}, 64'(bus.locked), 64'(t.e_locked));
        chk({tag, ".err_lane"}, 64'(bus.err_lane), 64'(t.e_lane));
        chk({tag, ".word_cnt"}, 64'(bus.word_cnt), 64'(t.e_word));
        chk({tag, ".bit_err_cnt"}, 64'(bus.bit_err_cnt), 64'(t.e_bit));
        chk({tag, ".err_sticky"}, 64'(bus.err_sticky), 64'(t.e_sticky));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.rx_valid = 1'b0;
        bus.clear_cnt = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [63:0] m_all;
        logic [63:0] m39;
        logic [63:0] m0;
        int lw;
        int lb;
        bit seen_lock;

        total = 0;
        bad   = 0;
        m_all = '1;
        m39   = 64'h0000_0080_0000_0000;
        m0    = 64'h1;

        tbl_a[0] = '{1'b1, 1'b0, 64'h0, 1'b0, 4'h0, 8'd0, 8'd0, 1'b0};
        tbl_a[1] = '{1'b1, 1'b0, 64'h0, 1'b0, 4'h0, 8'd0, 8'd0, 1'b0};
        tbl_a[2] = '{1'b1, 1'b0, 64'h0, 1'b0, 4'h0, 8'd0, 8'd0, 1'b0};
        tbl_a[3] = '{1'b1, 1'b0, 64'h0, 1'b0, 4'h0, 8'd0, 8'd0, 1'b0};
        tbl_a[4] = '{1'b1, 1'b0, 64'h0, 1'b1, 4'h0, 8'd0, 8'd0, 1'b0};

        tbl_b[0]  = '{1'b1, 1'b0, 64'h0,  1'b1, 4'h0, 8'd101, 8'd0,   1'b0};
        tbl_b[1]  = '{1'b1, 1'b0, m39,    1'b1, 4'h4, 8'd102, 8'd1,   1'b1};
        tbl_b[2]  = '{1'b1, 1'b0, 64'h0,  1'b1, 4'h0, 8'd103, 8'd1,   1'b1};
        tbl_b[3]  = '{1'b1, 1'b0, m_all,  1'b1, 4'hF, 8'd104, 8'd65,  1'b1};
        tbl_b[4]  = '{1'b1, 1'b0, m_all,  1'b1, 4'hF, 8'd105, 8'd129, 1'b1};
        tbl_b[5]  = '{1'b1, 1'b0, m_all,  1'b1, 4'hF, 8'd106, 8'd193, 1'b1};
        tbl_b[6]  = '{1'b1, 1'b0, 64'h0,  1'b1, 4'h0, 8'd107, 8'd193, 1'b1};
        tbl_b[7]  = '{1'b1, 1'b0, m_all,  1'b1, 4'hF, 8'd108, 8'd255, 1'b1};
        tbl_b[8]  = '{1'b1, 1'b0, m_all,  1'b1, 4'hF, 8'd109, 8'd255, 1'b1};
        tbl_b[9]  = '{1'b1, 1'b0, 64'h0,  1'b1, 4'h0, 8'd110, 8'd255, 1'b1};
        tbl_b[10] = '{1'b0, 1'b1, 64'h0,  1'b1, 4'h0, 8'd0,   8'd0,   1'b0};
        tbl_b[11] = '{1'b1, 1'b1, 64'h0,  1'b1, 4'h0, 8'd1,   8'd0,   1'b0};
        tbl_b[12] = '{1'b1, 1'b1, m0,     1'b1, 4'h1, 8'd1,   8'd1,   1'b1};
        tbl_b[13] = '{1'b0, 1'b0, 64'h0,  1'b1, 4'h1, 8'd1,   8'd1,   1'b1};
        tbl_b[14] = '{1'b1, 1'b0, 64'h0,  1'b1, 4'h0, 8'd2,   8'd1,   1'b1};

        reset = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = '0;
        bus.clear_cnt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.locked", 64'(bus.locked), 64'h0);
        chk("rst.word_cnt", 64'(bus.word_cnt), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) step(1'b0, 64'h0, 1'b0);
        chk("idle.locked", 64'(bus.locked), 64'h0);
        chk("idle.err_lane", 64'(bus.err_lane), 64'h0);
        chk("idle.bit_err_cnt", 64'(bus.bit_err_cnt), 64'h0);
        chk("idle.err_sticky", 64'(bus.err_sticky), 64'h0);

        gen = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 5; i++) run_vec(tbl_a[i], $sformatf("acq%0d", i));
        for (int i = 0; i < 100; i++) begin
            step(1'b1, gen, 1'b0);
            gen = nxt64(gen);
        end
        chk("run100.word_cnt", 64'(bus.word_cnt), 64'd100);
        chk("run100.bit_err_cnt", 64'(bus.bit_err_cnt), 64'd0);
        chk("run100.err_sticky", 64'(bus.err_sticky), 64'd0);
        chk("run100.err_lane", 64'(bus.err_lane), 64'd0);
        for (int i = 0; i < 15; i++) run_vec(tbl_b[i], $sformatf("err%0d", i));

        lw = 2;
        lb = 1;
        for (int k = 0; k < 4; k++) begin
            lb = lb + $countones(gen);
            if (lb > 255) lb = 255;
            gen = nxt64(gen);
            step(1'b1, 64'h0, 1'b0);
            lw++;
            chk($sformatf("loss%0d.locked", k), 64'(bus.locked), (k < 3) ? 64'h1 : 64'h0);
        end
        chk("loss.word_cnt", 64'(bus.word_cnt), 64'(lw));
        chk("loss.bit_err_cnt", 64'(bus.bit_err_cnt), 64'(lb));
        chk("loss.err_lane", 64'(bus.err_lane), 64'h0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, gen, 1'b0);
            gen = nxt64(gen);
            chk($sformatf("relock%0d.locked", k), 64'(bus.locked), (k == 4) ? 64'h1 : 64'h0);
        end
        chk("relock.word_cnt", 64'(bus.word_cnt), 64'(lw));
        chk("relock.bit_err_cnt", 64'(bus.bit_err_cnt), 64'(lb));
        chk("relock.err_sticky", 64'(bus.err_sticky), 64'h1);

        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst.locked", 64'(bus.locked), 64'h0);
        chk("async_rst.word_cnt", 64'(bus.word_cnt), 64'h0);
        chk("async_rst.err_sticky", 64'(bus.err_sticky), 64'h0);
        do_reset();

        gen = 64'h0123_4567_89AB_FFFF;
        seen_lock = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1'b1, gen, 1'b0);
            gen = nxt64(gen);
            if (bus.locked) seen_lock = 1'b1;
        end
        chk("lockup.ever_locked", 64'(seen_lock), 64'h0);
        chk("lockup.word_cnt", 64'(bus.word_cnt), 64'h0);

        do_reset();
        gen = 64'hDEAD_BEEF_1234_5678;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, gen, 1'b0);
            gen = nxt64(gen);
        end
        chk("gap.lock", 64'(bus.locked), 64'h1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, gen, 1'b0);
            gen = nxt64(gen);
            for (int g = 0; g < 3; g++) step(1'b0, {$urandom, $urandom}, 1'b0);
        end
        chk("gap.locked", 64'(bus.locked), 64'h1);
        chk("gap.bit_err_cnt", 64'(bus.bit_err_cnt), 64'h0);
        chk("gap.word_cnt", 64'(bus.word_cnt), 64'd20);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, gen, 1'b0);
            gen = nxt64(gen);
        end
        chk("sat.word_cnt", 64'(bus.word_cnt), 64'd255);
        chk("sat.bit_err_cnt", 64'(bus.bit_err_cnt), 64'd0);
        chk("sat.locked", 64'(bus.locked), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
